axis_sink_checker: RTL and testbench
====================================

Name: axis_sink_checker

Overview:
- Per-endpoint AXI-Stream sink and checker at one mesh output port.
- Accepts every packet the NoC delivers to endpoint TDEST, verifies routing fields and counts packets per source.
- Computes end-to-end latency from the injection timestamp carried in tdata and accumulates it.
- A top-level harness sums packet_count and total_latency across all endpoints for load-sweep characterization.

Parameters:
- COUNT_WIDTH, 32: width of all packet counters.
- TDEST, 0: this endpoint's ID; the only legal axis_in_tdest value.
- NUM_ROUTERS, 4: number of sources; depth of recv_packets; legal tid range 0..NUM_ROUTERS-1.
- TDATA_WIDTH, 512: stream data width; lower TDATA_WIDTH/2 bits carry the injection timestamp.
- TDEST_WIDTH, 2: tdest field width.
- TID_WIDTH, 2: tid field width.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous reset, active-high.
- ticks  input  TDATA_WIDTH/2  free-running global cycle counter, same timebase the generators stamp with.
- axis_in_tvalid  input  1  beat valid.
- axis_in_tready  output  1  beat ready.
- axis_in_tdata  input  TDATA_WIDTH  payload; bits [TDATA_WIDTH/2-1:0] = injection tick.
- axis_in_tlast  input  1  last beat of packet.
- axis_in_tid  input  TID_WIDTH  source endpoint ID.
- axis_in_tdest  input  TDEST_WIDTH  destination endpoint ID.
- recv_packets  output  NUM_ROUTERS x COUNT_WIDTH  unpacked array; completed packets per source tid.
- packet_count  output  COUNT_WIDTH  total completed packets.
- total_latency  output  TDATA_WIDTH/2  sum of per-packet latencies.
- error  output  1  sticky routing-error flag.

Behaviour:
- Reset (rst=1 at a clock edge):
  - packet_count, total_latency, every recv_packets entry, error and the internal in-packet flag/timestamp register all clear to 0.
  - axis_in_tready=0 during the cycle rst is asserted.
- Ready: axis_in_tready is registered, 1 from the first cycle after rst deasserts. The sink never backpressures.
- Beat accepted when tvalid && tready at a rising edge.
- Timestamp capture:
  - On the first accepted beat of a packet (internal in-packet flag = 0), latch tdata[TDATA_WIDTH/2-1:0] as ts.
  - Flag sets when the beat has tlast=0 and clears on the tlast beat.
  - Single-beat packet (first beat has tlast=1): its own tdata lower half is used directly.
  - Packets to one endpoint do not interleave; no per-tid timestamp storage.
- Completion on an accepted beat with tlast=1:
  - packet_count += 1.
  - recv_packets[tid] += 1, only if tid < NUM_ROUTERS.
  - total_latency += (ticks - ts), subtraction modulo 2^(TDATA_WIDTH/2). Timestamp wrap is therefore handled.
  - Latency uses the ticks value sampled at the same edge as the tlast beat.
  - All updates are registered and visible one cycle after the accepting edge.
- Error checks on every accepted beat, including non-last beats:
  - Set error if tdest != TDEST, or if tid >= NUM_ROUTERS.
  - error is sticky until reset.
  - A packet that flags an error is still counted in packet_count and total_latency. recv_packets is skipped only for out-of-range tid.
- Wrap-around: counters and total_latency wrap modulo 2^width with no saturation and no flag.
- Back-to-back packets every cycle are supported at full throughput; no bubble is required between tlast and the next first beat.
- tvalid=0 beats, and tdata/tid/tdest when not accepted, have no effect.
- Reset mid-packet: discards the in-progress packet, clears all state; the next accepted beat is treated as a first beat.

Test Plan:
- Reset: hold rst 3 cycles with tvalid=1 -> tready=0, no counts; tready=1 one cycle after release; all outputs 0.
- Single-beat latency: TDEST=2, inject tid=1, tdest=2, tlast=1, tdata low=100 at ticks=130 -> next cycle packet_count=1, recv_packets[1]=1, total_latency=30, error=0.
- Multi-beat packet:
  - Beats at ticks 50, 51, 52 (tlast on third), first-beat timestamp 40, later beats carry garbage timestamps -> latency 12, packet_count=1.
  - Back-to-back tid=3 packet, ts=60, tlast at ticks=53 -> wraps to 2^(TDATA_WIDTH/2)-7 added.
- Throughput: 16 consecutive single-beat packets, tids cycling 0..3, constant latency 5 -> packet_count=16, each recv_packets=4, total_latency=80, tready high throughout.
- Misroute: one beat with tdest=1 at TDEST=2 -> error=1 next cycle and stays 1 after further good packets; packet still counted; cleared only by rst.
- Bad tid: NUM_ROUTERS=3 with TID_WIDTH=2, tid=3 -> error=1, packet_count increments, no recv_packets entry changes.

Source files
------------

// File: rtl/axis_sink_checker_if.sv
// AXI-Stream beat bundle used at a mesh endpoint output port.
// The master drives the beat; the slave returns tready.
interface axis_sink_checker_if #(
   parameter int TDATA_WIDTH = 512,
   parameter int TID_WIDTH   = 2,
   parameter int TDEST_WIDTH = 2
);
   logic                   tvalid;
   logic                   tready;
   logic [TDATA_WIDTH-1:0] tdata;
   logic                   tlast;
   logic [TID_WIDTH-1:0]   tid;
   logic [TDEST_WIDTH-1:0] tdest;

   modport master (output tvalid, output tdata, output tlast, output tid, output tdest,
                   input  tready);
   modport slave  (input  tvalid, input  tdata, input  tlast, input  tid, input  tdest,
                   output tready);
endinterface

// File: rtl/axis_sink_checker.sv
// Endpoint sink: always-ready consumer that checks routing fields, counts packets
// per source and accumulates end-to-end latency from the first-beat timestamp.
module axis_sink_checker #(
   parameter int COUNT_WIDTH = 32,
   parameter int TDEST       = 0,
   parameter int NUM_ROUTERS = 4,
   parameter int TDATA_WIDTH = 512,
   parameter int TDEST_WIDTH = 2,
   parameter int TID_WIDTH   = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [TDATA_WIDTH/2-1:0]   ticks,
   axis_sink_checker_if.slave         axis_in,
   output logic [COUNT_WIDTH-1:0]     recv_packets [NUM_ROUTERS],
   output logic [COUNT_WIDTH-1:0]     packet_count,
   output logic [TDATA_WIDTH/2-1:0]   total_latency,
   output logic                       error
);
   localparam int TS_W = TDATA_WIDTH / 2;

   logic                   tready_reg;
   logic                   in_pkt_reg;
   logic [TS_W-1:0]        ts_reg;
   logic [COUNT_WIDTH-1:0] packet_count_reg;
   logic [TS_W-1:0]        total_latency_reg;
   logic                   error_reg;

   logic                   accept;
   logic                   completing;
   logic [TS_W-1:0]        first_ts;
   logic [TS_W-1:0]        latency;
   logic [31:0]            tid_ext;
   logic                   tid_ok;
   logic                   dest_ok;

   always_comb begin
      accept     = axis_in.tvalid && tready_reg;
      completing = accept && axis_in.tlast;
      // A single-beat packet uses its own timestamp; later beats reuse the latched one.
      first_ts   = in_pkt_reg ? ts_reg : axis_in.tdata[TS_W-1:0];
      latency    = ticks - first_ts;
      tid_ext    = {{(32-TID_WIDTH){1'b0}}, axis_in.tid};
      tid_ok     = tid_ext < 32'(NUM_ROUTERS);
      dest_ok    = axis_in.tdest == TDEST_WIDTH'(TDEST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tready_reg        <= 1'b0;
         in_pkt_reg        <= 1'b0;
         ts_reg            <= '0;
         packet_count_reg  <= '0;
         total_latency_reg <= '0;
         error_reg         <= 1'b0;
      end else begin
         tready_reg <= 1'b1;
         if (accept) begin
            in_pkt_reg <= !axis_in.tlast;
            if (!in_pkt_reg)
               ts_reg <= axis_in.tdata[TS_W-1:0];
            if (!dest_ok || !tid_ok)
               error_reg <= 1'b1;
         end
         if (completing) begin
            packet_count_reg  <= packet_count_reg + COUNT_WIDTH'(1);
            total_latency_reg <= total_latency_reg + latency;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_ROUTERS; gi++) begin : g_recv
         logic [COUNT_WIDTH-1:0] cnt_reg;
         always_ff @(posedge clk) begin
            if (rst)
               cnt_reg <= '0;
            else if (completing && tid_ext == 32'(gi))
               cnt_reg <= cnt_reg + COUNT_WIDTH'(1);
         end
         assign recv_packets[gi] = cnt_reg;
      end
   endgenerate

   assign axis_in.tready = tready_reg;
   assign packet_count   = packet_count_reg;
   assign total_latency  = total_latency_reg;
   assign error          = error_reg;
endmodule

// File: tb/tb_axis_sink_checker.sv
// Directed bench: dut_a (TDEST=2, 4 sources) for the main function, dut_b
// (TDEST=2, 3 sources) for the out-of-range tid check.
module tb_axis_sink_checker;
   localparam int CW  = 32;
   localparam int DW  = 512;
   localparam int TSW = DW / 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [TSW-1:0] ticks = '0;

   axis_sink_checker_if #(.TDATA_WIDTH(DW), .TID_WIDTH(2), .TDEST_WIDTH(2)) a_if ();
   axis_sink_checker_if #(.TDATA_WIDTH(DW), .TID_WIDTH(2), .TDEST_WIDTH(2)) b_if ();

   logic [CW-1:0]  a_recv [4];
   logic [CW-1:0]  a_count;
   logic [TSW-1:0] a_lat;
   logic           a_err;
   logic [CW-1:0]  b_recv [3];
   logic [CW-1:0]  b_count;
   logic [TSW-1:0] b_lat;
   logic           b_err;

   int tests  = 0;
   int failed = 0;

   axis_sink_checker #(.COUNT_WIDTH(CW), .TDEST(2), .NUM_ROUTERS(4), .TDATA_WIDTH(DW),
                       .TDEST_WIDTH(2), .TID_WIDTH(2)) dut_a (
      .clk(clk), .rst(rst), .ticks(ticks), .axis_in(a_if),
      .recv_packets(a_recv), .packet_count(a_count), .total_latency(a_lat), .error(a_err));

   axis_sink_checker #(.COUNT_WIDTH(CW), .TDEST(2), .NUM_ROUTERS(3), .TDATA_WIDTH(DW),
                       .TDEST_WIDTH(2), .TID_WIDTH(2)) dut_b (
      .clk(clk), .rst(rst), .ticks(ticks), .axis_in(b_if),
      .recv_packets(b_recv), .packet_count(b_count), .total_latency(b_lat), .error(b_err));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [TSW-1:0] obs, input logic [TSW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present one beat on dut_a, let one rising edge pass, return 1ns after it.
   task automatic beat_a(input logic v, input logic [1:0] tid, input logic [1:0] tdest,
                         input logic last, input logic [TSW-1:0] ts, input logic [TSW-1:0] tk);
      a_if.tvalid = v;
      a_if.tid    = tid;
      a_if.tdest  = tdest;
      a_if.tlast  = last;
      a_if.tdata  = {~ts, ts};
      ticks       = tk;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      a_if.tvalid = 1'b0;
      b_if.tvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_if.tvalid = 1'b1; a_if.tid = 2'd1; a_if.tdest = 2'd2; a_if.tlast = 1'b1;
      a_if.tdata = '0;
      b_if.tvalid = 1'b0; b_if.tid = 2'd0; b_if.tdest = 2'd2; b_if.tlast = 1'b1;
      b_if.tdata = '0;

      // Reset held 3 cycles with tvalid high
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst_tready", a_if.tready, 0);
         chk("rst_count", a_count, 0);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      a_if.tvalid = 1'b0;
      chk("post_rst_tready", a_if.tready, 1);
      chk("post_rst_count", a_count, 0);
      chk("post_rst_lat", a_lat, 0);
      chk("post_rst_err", a_err, 0);
      for (int i = 0; i < 4; i++) chk("post_rst_recv", a_recv[i], 0);

      // Single-beat latency: ts=100, ticks=130
      beat_a(1, 2'd1, 2'd2, 1, 100, 130);
      chk("single_count", a_count, 1);
      chk("single_recv1", a_recv[1], 1);
      chk("single_lat", a_lat, 30);
      chk("single_err", a_err, 0);

      // Idle cycle with garbage fields has no effect
      beat_a(0, 2'd3, 2'd0, 1, 7, 999);
      chk("idle_count", a_count, 1);
      chk("idle_err", a_err, 0);

      // Multi-beat packet, ts=40, later beats carry garbage timestamps
      beat_a(1, 2'd0, 2'd2, 0, 40, 50);
      chk("mb1_count", a_count, 1);
      beat_a(1, 2'd0, 2'd2, 0, 999, 51);
      beat_a(1, 2'd0, 2'd2, 1, 7, 52);
      chk("mb_count", a_count, 2);
      chk("mb_lat", a_lat, 42);
      chk("mb_recv0", a_recv[0], 1);
      // Back-to-back tid=3, ts=60 at ticks=53: adds 2^256-7, so 42-7 = 35
      beat_a(1, 2'd3, 2'd2, 1, 60, 53);
      chk("wrap_count", a_count, 3);
      chk("wrap_lat", a_lat, 35);
      chk("wrap_recv3", a_recv[3], 1);

      // Reset mid-packet: stale ts=500 must be discarded
      beat_a(1, 2'd2, 2'd2, 0, 500, 501);
      do_reset();
      chk("midrst_count", a_count, 0);
      chk("midrst_lat", a_lat, 0);

      // Throughput: 16 single-beat packets, latency 5 each
      for (int i = 0; i < 16; i++) begin
         chk("thru_tready", a_if.tready, 1);
         beat_a(1, 2'(i % 4), 2'd2, 1, TSW'(995 + i), TSW'(1000 + i));
      end
      a_if.tvalid = 1'b0;
      chk("thru_count", a_count, 16);
      chk("thru_lat", a_lat, 80);
      for (int i = 0; i < 4; i++) chk("thru_recv", a_recv[i], 4);
      chk("thru_err", a_err, 0);

      // Misroute: tdest=1 at TDEST=2, still counted
      beat_a(1, 2'd0, 2'd1, 1, 10, 12);
      chk("misroute_err", a_err, 1);
      chk("misroute_count", a_count, 17);
      chk("misroute_lat", a_lat, 82);
      chk("misroute_recv0", a_recv[0], 5);
      beat_a(1, 2'd1, 2'd2, 1, 20, 21);
      beat_a(0, 2'd1, 2'd2, 1, 20, 21);
      chk("sticky_err", a_err, 1);
      chk("sticky_count", a_count, 18);
      do_reset();
      chk("err_cleared", a_err, 0);

      // Bad tid on 3-source instance
      chk("b_pre_err", b_err, 0);
      b_if.tvalid = 1'b1; b_if.tid = 2'd3; b_if.tdest = 2'd2; b_if.tlast = 1'b1;
      b_if.tdata = {TSW'(0), TSW'(200)};
      ticks = 204;
      @(posedge clk);
      #1;
      b_if.tvalid = 1'b0;
      chk("badtid_err", b_err, 1);
      chk("badtid_count", b_count, 1);
      chk("badtid_lat", b_lat, 4);
      for (int i = 0; i < 3; i++) chk("badtid_recv", b_recv[i], 0);
      chk("badtid_other_dut", a_count, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
